// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and lane decode for the SRAM slave.
package ahb_slave_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam int unsigned WAIT_CNT_W = 3;

    // Byte lanes touched by a transfer of the given size at the given byte offset.
    function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] ofs);
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << ofs;
            HSIZE_HALF: lanes = ofs[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lanes = 4'b1111;
            default:    lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_slv_sram.sv
// Word-wide SRAM array: asynchronous read, synchronous byte-enabled write.
module ahb_slv_sram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    assign rdata_o = mem_q[raddr_i];

    // Write only the enabled byte lanes; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM responder with programmable wait states and byte-lane writes.
// Optional feature macro: AHB_SLV_ERR_RESP_EN -- when defined, out-of-range,
// misaligned or unsupported-size transfers get a two-cycle ERROR response;
// otherwise they complete OKAY with reads returning 0 and writes dropped.
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hselx,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);

    logic [2:0]            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  write_q, write_d;
    logic [3:0]            lanes_q, lanes_d;
    logic                  bad_q, bad_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [1:0]            hresp_q, hresp_d;

    logic        is_active;
    logic        accept;
    logic [31:0] offset;
    logic        in_range;
    logic        misaligned;
    logic        bad_xfer;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] fwd_word;

    // Address-phase qualification and range/alignment check.
    always_comb begin
        is_active = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: is_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  is_active = 1'b0;
            default:                   is_active = 1'b0;
        endcase
        offset     = haddr - BASE_ADDR;
        in_range   = (offset < WIN_BYTES);
        misaligned = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
        bad_xfer   = !in_range || misaligned || (hsize > HSIZE_WORD);
        // Only the ready states (IDLE/DATA/ERR2) can take a new address phase.
        accept     = hselx && hready && is_active && hreadyout_q;
    end

    // Write commits on the edge that ends the DATA cycle; reset drops it.
    assign wr_en = (state_q == ST_DATA) && write_q && !bad_q && !hreset;

    ahb_slv_sram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk_i   (hclk),
        .we_i    (wr_en),
        .waddr_i (addr_q),
        .be_i    (lanes_q),
        .wdata_i (hwdata),
        .raddr_i (addr_d),
        .rdata_o (rd_word)
    );

    // Next-state logic: transfer sequencing and address/control latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        lanes_d    = lanes_q;
        bad_d      = bad_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d     = offset[AW+1:2];
                    write_d    = hwrite;
                    lanes_d    = lane_decode(hsize, haddr[1:0]);
                    bad_d      = bad_xfer;
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                    wait_cnt_d = WAIT_CNT_W'(WAIT_STATES - 1);
`ifdef AHB_SLV_ERR_RESP_EN
                    if (bad_xfer) begin
                        state_d = ST_ERR1;
                    end
`endif
                end
            end
        endcase
    end

    // Output decode from the next state; write data being committed this edge
    // is forwarded so a read of the same word right behind it sees new data.
    always_comb begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        hrdata_d    = hrdata_q;
        fwd_word    = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && lanes_q[b] && (addr_q == addr_d)) begin
                fwd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
        case (state_d)
            ST_WAIT: hreadyout_d = 1'b0;
            ST_DATA: begin
                if (!write_d) begin
                    hrdata_d = bad_d ? 32'h0 : fwd_word;
                end
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            ST_ERR2: hresp_d = HRESP_ERROR;
            default: ;
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            lanes_q     <= '0;
            bad_q       <= 1'b0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            lanes_q     <= lanes_d;
            bad_q       <= bad_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign hrdata    = hrdata_q;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: a WAIT_STATES=2 and a WAIT_STATES=0 instance
// share one pipelined master; the bus ready is muxed from the slave in use.
module tb_ahb_slave_mem;
    import ahb_slave_mem_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hselx;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        use_w0;

    logic [31:0] hrdata_w2, hrdata_w0, hrdata_m;
    logic        hreadyout_w2, hreadyout_w0;
    logic [1:0]  hresp_w2, hresp_w0, hresp_m;

    int n_total = 0;
    int n_bad   = 0;
    int cur_ws  = 2;

    typedef struct {
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  low_resp;
        logic [1:0]  resp;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 hclk = ~hclk;

    assign hready   = use_w0 ? hreadyout_w0 : hreadyout_w2;
    assign hrdata_m = use_w0 ? hrdata_w0 : hrdata_w2;
    assign hresp_m  = use_w0 ? hresp_w0 : hresp_w2;

    ahb_slave_mem #(.MEM_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
        .hclk      (hclk),
        .hreset    (hreset),
        .hselx     (hselx && !use_w0),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata_w2),
        .hreadyout (hreadyout_w2),
        .hresp     (hresp_w2)
    );

    ahb_slave_mem #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .hclk      (hclk),
        .hreset    (hreset),
        .hselx     (hselx && use_w0),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata_w0),
        .hreadyout (hreadyout_w0),
        .hresp     (hresp_w0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One address phase; completes the pending data phase against the scoreboard.
    task automatic bus_step(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz, input exp_t e);
        exp_t cur;
        logic rdy;
        int   waits;
        bit   done;
        hselx  = tr[1];
        htrans = tr;
        haddr  = a;
        hwrite = e.wr;
        hsize  = sz;
        hwdata = (exp_q.size() > 0) ? exp_q[0].wdata : 32'h0;
        waits  = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge hclk);
            rdy = hready;
            if (exp_q.size() > 0) begin
                if (!rdy) begin
                    waits++;
                    check("resp_low", 32'(hresp_m), 32'(exp_q[0].low_resp));
                end else begin
                    cur = exp_q.pop_front();
                    check("waits", 32'(waits), 32'(cur.waits));
                    check("resp", 32'(hresp_m), 32'(cur.resp));
                    if (cur.chk_rd) check("rdata", hrdata_m, cur.rdata);
                end
            end
            @(posedge hclk);
            #1;
            done = rdy;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        if (done && tr[1]) exp_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        exp_t e;
        e.wr = 1'b1; e.wdata = d; e.rdata = 32'h0; e.waits = cur_ws;
        e.low_resp = HRESP_OKAY; e.resp = HRESP_OKAY; e.chk_rd = 1'b0;
        bus_step(tr, a, sz, e);
    endtask

    task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] exp_d);
        exp_t e;
        e.wr = 1'b0; e.wdata = 32'h0; e.rdata = exp_d; e.waits = cur_ws;
        e.low_resp = HRESP_OKAY; e.resp = HRESP_OKAY; e.chk_rd = 1'b1;
        bus_step(tr, a, HSIZE_WORD, e);
    endtask

    task automatic bad_xfer(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        exp_t e;
        e.wr = w; e.wdata = d; e.rdata = 32'h0;
`ifdef AHB_SLV_ERR_RESP_EN
        e.waits = 1; e.low_resp = HRESP_ERROR; e.resp = HRESP_ERROR; e.chk_rd = 1'b0;
`else
        e.waits = cur_ws; e.low_resp = HRESP_OKAY; e.resp = HRESP_OKAY; e.chk_rd = !w;
`endif
        bus_step(HTRANS_NONSEQ, a, sz, e);
    endtask

    task automatic idle();
        exp_t e;
        e.wr = 1'b0; e.wdata = 32'h0; e.rdata = 32'h0; e.waits = 0;
        e.low_resp = HRESP_OKAY; e.resp = HRESP_OKAY; e.chk_rd = 1'b0;
        bus_step(HTRANS_IDLE, 32'h0, HSIZE_WORD, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge hclk);
        check({tag, "_rdy_w2"},  32'(hreadyout_w2), 32'd1);
        check({tag, "_resp_w2"}, 32'(hresp_w2), 32'(HRESP_OKAY));
        check({tag, "_data_w2"}, hrdata_w2, 32'h0);
        check({tag, "_rdy_w0"},  32'(hreadyout_w0), 32'd1);
        check({tag, "_resp_w0"}, 32'(hresp_w0), 32'(HRESP_OKAY));
        check({tag, "_data_w0"}, hrdata_w0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hreset = 1'b1; hselx = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0; use_w0 = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        check_reset_outputs("reset");
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // Two wait states on every OKAY data phase.
        cur_ws = 2;
        wr(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
        rd(HTRANS_NONSEQ, 32'h10, 32'hDEAD_BEEF);
        idle();

        // Sub-word writes land on their own lanes only.
        wr(HTRANS_NONSEQ, 32'h11, HSIZE_BYTE, 32'h0000_AA00);
        wr(HTRANS_NONSEQ, 32'h12, HSIZE_HALF, 32'h5566_0000);
        rd(HTRANS_NONSEQ, 32'h10, 32'h5566_AAEF);
        idle();
        @(negedge hclk);
        check("hold", hrdata_m, 32'h5566_AAEF);
        @(posedge hclk);
        #1;

        // Out-of-range read and misaligned write; next address is taken in ERR2.
        bad_xfer(1'b0, 32'h0000_1000, HSIZE_WORD, 32'h0);
        rd(HTRANS_NONSEQ, 32'h10, 32'h5566_AAEF);
        bad_xfer(1'b1, 32'h12, HSIZE_WORD, 32'hFFFF_FFFF);
        rd(HTRANS_NONSEQ, 32'h10, 32'h5566_AAEF);
        idle();

        // Reset in the wait phase of a write drops the write.
        wr(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0000_0001);
        rd(HTRANS_NONSEQ, 32'h20, 32'h0000_0001);
        idle();
        wr(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0000_0099);
        hreset = 1'b1; hselx = 1'b0; htrans = HTRANS_IDLE;
        repeat (2) @(posedge hclk);
        #1;
        exp_q.delete();
        check_reset_outputs("midreset");
        hreset = 1'b0;
        rd(HTRANS_NONSEQ, 32'h20, 32'h0000_0001);
        idle();

        // Zero-wait slave: pipelined bursts and read right behind a write.
        use_w0 = 1'b1;
        cur_ws = 0;
        wr(HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'h1111_1111);
        wr(HTRANS_SEQ,    32'h4, HSIZE_WORD, 32'h2222_2222);
        wr(HTRANS_SEQ,    32'h8, HSIZE_WORD, 32'h3333_3333);
        rd(HTRANS_NONSEQ, 32'h0, 32'h1111_1111);
        rd(HTRANS_SEQ,    32'h4, 32'h2222_2222);
        rd(HTRANS_SEQ,    32'h8, 32'h3333_3333);
        wr(HTRANS_NONSEQ, 32'hC, HSIZE_WORD, 32'hA5A5_5A5A);
        rd(HTRANS_NONSEQ, 32'hC, 32'hA5A5_5A5A);
        bad_xfer(1'b0, 32'h0000_1000, HSIZE_WORD, 32'h0);
        idle();
        idle();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
